// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: cause-bit layout, sequencer states
// and a helper for sizing counters that must never collapse to zero width.
package reset_seq_pkg;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_PLL = 1;
    localparam int CAUSE_EXT = 2;
    localparam int CAUSE_SW  = 3;

    localparam logic [3:0] POR_CAUSE = 4'(1 << CAUSE_POR);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // A delay of 1 still needs a 1-bit counter that sits at its terminal value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync_debounce.sv
// Two-flop synchronizer followed by a saturating debounce counter; active asserts
// after DEBOUNCE consecutive active samples and drops on the first inactive one.
module rst_sync_debounce #(
    parameter int DEBOUNCE    = 16,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk_core,
    input  logic reset_n,
    input  logic async_in,
    output logic active
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          active_reg;
    logic          sample_active;

    assign sample_active = ACTIVE_HIGH ? sync_reg[1] : ~sync_reg[1];
    assign active        = active_reg;

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg   <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], async_in};
            if (!sample_active) begin
                cnt_reg    <= '0;
                active_reg <= 1'b0;
            end else if (cnt_reg != CNT_MAX) begin
                // Once saturated the counter and active flag simply hold.
                cnt_reg    <= cnt_reg + CW'(1);
                active_reg <= (cnt_reg == CNT_MAX - CW'(1));
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock and the board reset button, then releases NCH reset domains
// one after another; keeps a sticky record of why the last reset happened.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int LOCK_WINDOW     = 4,
    parameter int NCH             = 3,
    parameter int STAGE_DELAY     = 256,
    parameter int DEBOUNCE        = 16,
    parameter bit EXT_ACTIVE_HIGH = 1'b1
) (
    input  logic           clk_core,
    input  logic           reset_n,
    input  logic           pll_locked,
    input  logic           ext_reset,
    input  logic           sw_reset_req,
    input  logic           cause_clr,
    output logic [NCH-1:0] rst_out_n,
    output logic           lock_stable,
    output logic           seq_done,
    output logic [3:0]     cause
);

    localparam int CNT_W = cnt_width(STAGE_DELAY);
    localparam int IDX_W = $clog2(NCH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    genvar gi;

    logic pll_act;
    logic ext_act;

    // With DEBOUNCE=1 the active flag is the synchronized lock delayed one edge,
    // so it doubles as the first tap of the lock window.
    rst_sync_debounce #(
        .DEBOUNCE    (1),
        .ACTIVE_HIGH (1'b1)
    ) u_pll_sync (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .async_in (pll_locked),
        .active   (pll_act)
    );

    rst_sync_debounce #(
        .DEBOUNCE    (DEBOUNCE),
        .ACTIVE_HIGH (EXT_ACTIVE_HIGH)
    ) u_ext_debounce (
        .clk_core (clk_core),
        .reset_n  (reset_n),
        .async_in (ext_reset),
        .active   (ext_act)
    );

    logic [LOCK_WINDOW-1:0] window;
    logic                   lock_stable_reg;

    assign window[0] = pll_act;
    for (gi = 1; gi < LOCK_WINDOW; gi++) begin : g_tap
        logic tap_reg;
        always_ff @(posedge clk_core or negedge reset_n) begin
            if (!reset_n) tap_reg <= 1'b0;
            else          tap_reg <= window[gi-1];
        end
        assign window[gi] = tap_reg;
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) lock_stable_reg <= 1'b0;
        else          lock_stable_reg <= &window;
    end

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [NCH-1:0]   rst_reg, rst_next;
    logic             done_reg, done_next;
    logic [3:0]       cause_reg, cause_next;
    logic [3:0]       cause_set;
    logic             hold_cond;
    logic             stage_last;
    logic [NCH-1:0]   release_hit;

    assign hold_cond  = !lock_stable_reg || ext_act || (sw_reset_req && state_reg == RUN);
    assign stage_last = (state_reg == STAGE) && (cnt_reg == CNT_LAST);

    for (gi = 0; gi < NCH; gi++) begin : g_release
        assign release_hit[gi] = stage_last && (idx_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rst_reg   <= '0;
            done_reg  <= 1'b0;
            cause_reg <= POR_CAUSE;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rst_reg   <= rst_next;
            done_reg  <= done_next;
            cause_reg <= cause_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        rst_next   = rst_reg;
        done_next  = done_reg;
        cause_next = cause_clr ? 4'b0000 : cause_reg;

        cause_set            = '0;
        cause_set[CAUSE_PLL] = !lock_stable_reg;
        cause_set[CAUSE_EXT] = ext_act;
        cause_set[CAUSE_SW]  = sw_reset_req;

        if (hold_cond) begin
            state_next = HOLD;
            cnt_next   = '0;
            idx_next   = '0;
            rst_next   = '0;
            done_next  = 1'b0;
            // A simultaneous clear only wipes the old bits, never the new ones.
            if (state_reg != HOLD) cause_next = cause_next | cause_set;
        end else begin
            case (state_reg)
                HOLD: begin
                    state_next = STAGE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                STAGE: begin
                    if (stage_last) begin
                        cnt_next = '0;
                        idx_next = idx_reg + IDX_W'(1);
                        rst_next = rst_reg | release_hit;
                        if (idx_reg == IDX_LAST) begin
                            state_next = RUN;
                            done_next  = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_next  = '1;
                    done_next = 1'b1;
                end
                default: state_next = HOLD;
            endcase
        end
    end

    assign rst_out_n   = rst_reg;
    assign lock_stable = lock_stable_reg;
    assign seq_done    = done_reg;
    assign cause       = cause_reg;

endmodule
